// File: rtl/wide_add_sequencer.sv
// Multi-cycle WIDTH-bit adder/subtractor that walks one nibble per cycle,
// least significant first, through a shared 4-bit ripple-carry slice.

module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];
endmodule

// state | meaning
// IDLE  | waiting for an operation, in_ready high
// RUN   | one nibble per cycle through the slice, index counts up
// DONE  | result presented with out_valid, held until out_ready
module wide_add_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);
  localparam int NCHUNK = WIDTH / 4;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result;
  logic             carry_reg;
  logic [IW-1:0]    idx;

  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [3:0]       slice_sum;
  logic             slice_cout;

  assign slice_a = a_reg[{idx, 2'b00} +: 4];
  assign slice_b = b_reg[{idx, 2'b00} +: 4];

  ripple_carry_adder u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Gated by rst_n so the producer never sees ready while reset is held.
  assign in_ready = rst_n && (state == IDLE);
  assign sum      = result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      result    <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= op_sub ? ~b : b;
            carry_reg <= op_sub;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          result[{idx, 2'b00} +: 4] <= slice_sum;
          carry_reg <= slice_cout;
          idx       <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            // Top nibble: the slice MSB is the final sum MSB.
            carry_out <= slice_cout;
            overflow  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                         (slice_sum[3] != a_reg[WIDTH-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer: expectations queued at acceptance,
// compared when the result handshake happens.

module tb_wide_add_sequencer;
  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;

  // {overflow, carry_out, sum}
  logic [W+1:0] sb[$];
  logic [W+1:0] exp_mon;

  wide_add_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
    logic [W:0] r;
    logic       ov;
    if (!s) begin
      r  = {1'b0, x} + {1'b0, y};
      ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r[W-1:0] = x - y;
      r[W]     = (x >= y);
      ov       = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end
    return {ov, r};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        exp_mon = sb.pop_front();
        chk("sum", 32'(sum), 32'(exp_mon[W-1:0]));
        chk("carry_out", 32'(carry_out), 32'(exp_mon[W]));
        chk("overflow", 32'(overflow), 32'(exp_mon[W+1]));
      end
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                      input logic [W+1:0] e);
    int n;
    a        = ta;
    b        = tb_v;
    op_sub   = ts;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      sb.push_back(e);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         s;
    logic [W+1:0] e;
  } vec_t;

  vec_t dir[6];
  int   lat;
  int   cnt;
  logic [W+1:0] e1;
  logic [W+1:0] e2;

  initial begin
    dir[0] = '{16'h1234, 16'h0FFF, 1'b0, {1'b0, 1'b0, 16'h2233}};
    dir[1] = '{16'hFFFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h0000}};
    dir[2] = '{16'h7FFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h8000}};
    dir[3] = '{16'h0005, 16'h0007, 1'b1, {1'b0, 1'b0, 16'hFFFE}};
    dir[4] = '{16'h8000, 16'h0001, 1'b1, {1'b1, 1'b1, 16'h7FFF}};
    dir[5] = '{16'h1234, 16'h1234, 1'b1, {1'b0, 1'b1, 16'h0000}};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op_sub    = 1'b0;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Directed add/subtract cases, no backpressure
    for (int i = 0; i < 6; i++) begin
      send(dir[i].x, dir[i].y, dir[i].s, dir[i].e);
      chk("busy_after_accept", 32'(busy), 32'd1);
      wait_out(lat);
      chk("latency", 32'(lat), 32'd4);
      @(posedge clk); #1;
      chk("out_valid_pulse", 32'(out_valid), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
    end

    // Backpressure with a pending new operation
    out_ready = 1'b0;
    e1 = model(16'h4321, 16'h1111, 1'b0);
    send(16'h4321, 16'h1111, 1'b0, e1);
    wait_out(lat);
    chk("bp_latency", 32'(lat), 32'd4);
    a        = 16'hA5A5;
    b        = 16'h5A5A;
    op_sub   = 1'b1;
    in_valid = 1'b1;
    e2 = model(16'hA5A5, 16'h5A5A, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_sum_hold", 32'(sum), 32'(e1[W-1:0]));
      chk("bp_carry_hold", 32'(carry_out), 32'(e1[W]));
      chk("bp_ovf_hold", 32'(overflow), 32'(e1[W+1]));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    sb.push_back(e2);
    #1 in_valid = 1'b0;
    chk("bp_pending_accept", 32'(busy), 32'd1);
    wait_out(lat);
    chk("bp2_latency", 32'(lat), 32'd4);
    @(posedge clk); #1;

    // Operands altered during RUN must not matter
    send(16'h0F0F, 16'h00F1, 1'b0, model(16'h0F0F, 16'h00F1, 1'b0));
    a      = 16'hFFFF;
    b      = 16'hFFFF;
    op_sub = 1'b1;
    wait_out(lat);
    chk("chg_latency", 32'(lat), 32'd4);
    @(posedge clk); #1;

    // Reset in the middle of RUN
    send(16'h1111, 16'h2222, 1'b0, model(16'h1111, 16'h2222, 1'b0));
    @(posedge clk);
    @(posedge clk); #2;
    chk("mid_run_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mr_in_ready", 32'(in_ready), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_sum", 32'(sum), 32'd0);
    chk("mr_carry", 32'(carry_out), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("mr_rel_ready", 32'(in_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    chk("mr_no_valid", 32'(cnt), 32'd0);
    send(16'h0001, 16'h0001, 1'b0, {1'b0, 1'b0, 16'h0002});
    wait_out(lat);
    chk("mr_latency", 32'(lat), 32'd4);
    @(posedge clk); #1;

    // Random operations against the model
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] rx;
      logic [W-1:0] ry;
      logic         rs;
      rx = W'($urandom);
      ry = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      send(rx, ry, rs, model(rx, ry, rs));
      wait_out(lat);
      chk("rnd_latency", 32'(lat), 32'd4);
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
